// File: rtl/uart_defs.sv
// -----------------------------------------------------------------------------
// uart_defs
// Shared UART definitions used by both the receiver and the transmitter:
// data width, the default bit-period divider (50 MHz / 115200), and the
// receiver state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_defs;

  localparam int UART_DATA_BITS       = 8;
  localparam int UART_CLK_DIV_DEFAULT = 434;

  // Receiver states. ST_PARITY is only reachable in parity-enabled builds.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer for the asynchronous serial pin. Both flops reset
// to 1 so that a reset never looks like a start bit.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous, active-low reset
//   i_async  in   asynchronous input (idle high)
//   o_sync   out  synchronized copy of i_async, two cycles late
// -----------------------------------------------------------------------------
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // Plain two-stage shift toward the clock domain; reset state is "line idle".
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx_frame.sv
// -----------------------------------------------------------------------------
// uart_rx_frame
// Oversampling UART receiver: 8 data bits LSB first, one stop bit, optional
// even parity (compiled in when the macro UART_RX_PARITY_EN is defined).
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous, active-low reset
//   rxd          in   asynchronous serial input, idle high
//   rd_ack       in   one-cycle pulse, consumer has taken rdata
//   rdata        out  last good byte, held until the next good byte
//   rdata_valid  out  one-cycle pulse when rdata is updated
//   rx_ready     out  sticky, an unread byte is present
//   overrun      out  sticky, a byte arrived while rx_ready was still set
//   frame_err    out  one-cycle pulse, stop bit sampled low
//   parity_err   out  one-cycle pulse, parity mismatch (UART_RX_PARITY_EN only)
//   busy         out  high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_frame
  import uart_defs::*;
#(
  parameter int CLK_DIV = UART_CLK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       rd_ack,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  output logic       rx_ready,
  output logic       overrun,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(UART_DATA_BITS);
  localparam logic [DIV_W-1:0] DIV_HALF_LAST = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [DIV_W-1:0] DIV_FULL_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST      = BIT_W'(UART_DATA_BITS - 1);

  rx_state_e                  r_state;
  rx_state_e                  w_stateNext;
  logic [DIV_W-1:0]           r_div;
  logic [BIT_W-1:0]           r_bitCnt;
  logic [UART_DATA_BITS-1:0]  r_shift;
  logic [UART_DATA_BITS-1:0]  r_rdata;
  logic                       r_rdataValid;
  logic                       r_rxReady;
  logic                       r_overrun;
  logic                       r_frameErr;

  logic w_rxs;
  logic w_sampleHalf;
  logic w_sampleFull;
  logic w_clrDiv;
  logic w_clrBits;
  logic w_shiftEn;
  logic w_commit;
  logic w_frameErrSet;

`ifdef UART_RX_PARITY_EN
  logic r_parityBit;
  logic r_parityErr;
  logic w_capParity;
  logic w_parityErrSet;
  logic w_parityBad;

  // Even parity: data ones plus the parity bit must come to an even count.
  assign w_parityBad = (^r_shift) ^ r_parityBit;
`endif

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (rxd),
    .o_sync  (w_rxs)
  );

  assign w_sampleHalf = (r_div == DIV_HALF_LAST);
  assign w_sampleFull = (r_div == DIV_FULL_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and per-cycle control strobes. The start bit is checked at its
  // midpoint; every later bit is sampled one full period after the previous
  // sample, so all samples land mid-bit.
  always_comb begin
    w_stateNext    = r_state;
    w_clrDiv       = 1'b0;
    w_clrBits      = 1'b0;
    w_shiftEn      = 1'b0;
    w_commit       = 1'b0;
    w_frameErrSet  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_capParity    = 1'b0;
    w_parityErrSet = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (!w_rxs) begin
          w_stateNext = ST_START;
          w_clrDiv    = 1'b1;
          w_clrBits   = 1'b1;
        end
      end
      ST_START: begin
        if (w_sampleHalf) begin
          w_clrDiv    = 1'b1;
          w_stateNext = w_rxs ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_sampleFull) begin
          w_clrDiv  = 1'b1;
          w_shiftEn = 1'b1;
          if (r_bitCnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            w_stateNext = ST_PARITY;
`else
            w_stateNext = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (w_sampleFull) begin
          w_clrDiv    = 1'b1;
          w_capParity = 1'b1;
          w_stateNext = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (w_sampleFull) begin
          w_clrDiv = 1'b1;
`ifdef UART_RX_PARITY_EN
          w_parityErrSet = w_parityBad;
          w_commit       = w_rxs && !w_parityBad;
`else
          w_commit       = w_rxs;
`endif
          w_frameErrSet = !w_rxs;
          w_stateNext   = w_rxs ? ST_IDLE : ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (w_rxs) begin
          w_stateNext = ST_IDLE;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // Bit-period divider, bit counter and shift register. The divider free-runs
  // and is zeroed at every sample point; data shifts in from the top so the
  // first (LSB) bit ends up in bit 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_div    <= '0;
      r_bitCnt <= '0;
      r_shift  <= '0;
    end else begin
      r_div <= w_clrDiv ? '0 : r_div + DIV_W'(1);
      if (w_clrBits) begin
        r_bitCnt <= '0;
      end else if (w_shiftEn) begin
        r_bitCnt <= r_bitCnt + BIT_W'(1);
      end
      if (w_shiftEn) begin
        r_shift <= {w_rxs, r_shift[UART_DATA_BITS-1:1]};
      end
    end
  end

  // Output register and CPU handshake. A commit takes priority over rd_ack:
  // rx_ready stays set and overrun is only raised when an unread byte is
  // being overwritten without an acknowledge in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rdata      <= '0;
      r_rdataValid <= 1'b0;
      r_rxReady    <= 1'b0;
      r_overrun    <= 1'b0;
      r_frameErr   <= 1'b0;
    end else begin
      r_rdataValid <= w_commit;
      r_frameErr   <= w_frameErrSet;
      if (w_commit) begin
        r_rdata   <= r_shift;
        r_rxReady <= 1'b1;
        if (r_rxReady && !rd_ack) begin
          r_overrun <= 1'b1;
        end
      end else if (rd_ack) begin
        r_rxReady <= 1'b0;
        r_overrun <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity bit capture and its error pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_parityBit <= 1'b0;
      r_parityErr <= 1'b0;
    end else begin
      if (w_capParity) begin
        r_parityBit <= w_rxs;
      end
      r_parityErr <= w_parityErrSet;
    end
  end

  assign parity_err = r_parityErr;
`endif

  assign rdata       = r_rdata;
  assign rdata_valid = r_rdataValid;
  assign rx_ready    = r_rxReady;
  assign overrun     = r_overrun;
  assign frame_err   = r_frameErr;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_frame
// Self-checking bench for uart_rx_frame with CLK_DIV = 16. Frames are driven
// cycle by cycle on rxd; expected timing and register contents come from the
// frame arithmetic and a small handshake model kept here.
// Builds with or without UART_RX_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_uart_rx_frame;

  localparam int D = 16;
  localparam int H = D / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif
  // Cycle (counted from the pin falling edge) in which commit results show:
  // 2 sync cycles, half a bit to the start sample, NB bits to the stop sample.
  localparam int COMMIT = 2 + H + NB * D + 1;
  localparam int FRAME  = (NB + 1) * D;

  logic       clk;
  logic       rst;
  logic       rxd;
  logic       rd_ack;
  logic [7:0] rdata;
  logic       rdata_valid;
  logic       rx_ready;
  logic       overrun;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int errors = 0;
  int checks = 0;

  logic [7:0] expRdata;
  logic       expReady;
  logic       expOverrun;

  uart_rx_frame #(.CLK_DIV(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .rxd         (rxd),
    .rd_ack      (rd_ack),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .rx_ready    (rx_ready),
    .overrun     (overrun),
    .frame_err   (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err  (parity_err),
`endif
    .busy        (busy)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison with its failure report.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Line idle for n cycles.
  task automatic idleCycles(input int n);
    rxd    = 1'b1;
    rd_ack = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Compare the CPU-visible registers against the model.
  task automatic checkRegs(input string tag);
    checkOutput({tag, "_rdata"}, 32'(rdata), 32'(expRdata));
    checkOutput({tag, "_ready"}, 32'(rx_ready), 32'(expReady));
    checkOutput({tag, "_overrun"}, 32'(overrun), 32'(expOverrun));
  endtask

  // Single rd_ack pulse outside any commit.
  task automatic ackPulse(input string tag);
    rd_ack = 1'b1;
    @(posedge clk);
    #1;
    rd_ack     = 1'b0;
    expReady   = 1'b0;
    expOverrun = 1'b0;
    checkRegs(tag);
  endtask

  // Drive one complete frame starting right now (#1 after an edge) and check
  // pulse timing plus the resulting register state. ackCycle < 0 means no
  // acknowledge; otherwise rd_ack is high during that frame cycle.
  task automatic applyStimulus(input string tag, input logic [7:0] data,
                               input logic stopBit, input logic parityBit,
                               input int ackCycle);
    int  bitIdx;
    int  validAt, validCnt, ferrAt, ferrCnt, perrAt, perrCnt;
    logic busyMid;
    logic goodParity, good, ackAtCommit;
    validAt = -1; validCnt = 0; ferrAt = -1; ferrCnt = 0;
    perrAt  = -1; perrCnt  = 0; busyMid = 1'b0;
    for (int c = 0; c < FRAME; c++) begin
      bitIdx = c / D;
      if (bitIdx == 0)       rxd = 1'b0;
      else if (bitIdx <= 8)  rxd = data[bitIdx-1];
      else if (bitIdx == NB) rxd = stopBit;
      else                   rxd = parityBit;
      rd_ack = (c == ackCycle);
      @(posedge clk);
      #1;
      if (rdata_valid) begin validCnt++; validAt = c + 1; end
      if (frame_err)   begin ferrCnt++;  ferrAt  = c + 1; end
`ifdef UART_RX_PARITY_EN
      if (parity_err)  begin perrCnt++;  perrAt  = c + 1; end
`endif
      if (c + 1 == 20) busyMid = busy;
    end
    rd_ack = 1'b0;

`ifdef UART_RX_PARITY_EN
    goodParity = (parityBit == ^data);
`else
    goodParity = 1'b1;
`endif
    good        = stopBit && goodParity;
    ackAtCommit = (ackCycle == COMMIT - 1);

    checkOutput({tag, "_busy_mid"}, 32'(busyMid), 32'd1);
    checkOutput({tag, "_valid_cnt"}, validCnt, good ? 1 : 0);
    checkOutput({tag, "_valid_at"}, validAt, good ? COMMIT : -1);
    checkOutput({tag, "_ferr_cnt"}, ferrCnt, stopBit ? 0 : 1);
    checkOutput({tag, "_ferr_at"}, ferrAt, stopBit ? -1 : COMMIT);
`ifdef UART_RX_PARITY_EN
    checkOutput({tag, "_perr_at"}, perrAt, goodParity ? -1 : COMMIT);
    checkOutput({tag, "_perr_cnt"}, perrCnt, goodParity ? 0 : 1);
`else
    checkOutput({tag, "_perr_cnt"}, perrCnt + perrAt, -1);
`endif

    if (good) begin
      expOverrun = ackAtCommit ? expOverrun : (expOverrun | expReady);
      expReady   = 1'b1;
      expRdata   = data;
    end else if (ackCycle >= 0) begin
      expReady   = 1'b0;
      expOverrun = 1'b0;
    end
    checkRegs(tag);
  endtask

  initial begin
    int         firstBusy, busyCnt, evtCnt;
    logic [7:0] rnd;
    logic       stopRnd, parRnd, ackRnd;

    rst = 1'b0; rxd = 1'b1; rd_ack = 1'b0;
    expRdata = 8'h00; expReady = 1'b0; expOverrun = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state.
    checkRegs("reset");
    checkOutput("reset_valid", 32'(rdata_valid), 32'd0);
    checkOutput("reset_ferr", 32'(frame_err), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
`ifdef UART_RX_PARITY_EN
    checkOutput("reset_perr", 32'(parity_err), 32'd0);
`endif
    rst = 1'b1;
    idleCycles(4);

    // Good byte.
    applyStimulus("a5", 8'hA5, 1'b1, ^8'hA5, -1);
    idleCycles(3);

    // Four-cycle low glitch: START for cycles 3..10, then back to IDLE.
    firstBusy = -1; busyCnt = 0; evtCnt = 0;
    for (int c = 0; c < 20; c++) begin
      rxd = (c < 4) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      if (busy) begin
        busyCnt++;
        if (firstBusy < 0) firstBusy = c + 1;
      end
      if (rdata_valid || frame_err) evtCnt++;
    end
    checkOutput("glitch_first_busy", firstBusy, 3);
    checkOutput("glitch_busy_cnt", busyCnt, 8);
    checkOutput("glitch_events", evtCnt, 0);
    checkRegs("glitch");

    // Framing error, then a long break, then release.
    applyStimulus("ferr", 8'h3C, 1'b0, ^8'h3C, -1);
    repeat (40) @(posedge clk);
    #1;
    checkOutput("break_busy", 32'(busy), 32'd1);
    idleCycles(4);
    checkOutput("break_release_busy", 32'(busy), 32'd0);

    // Overrun and its clearing.
    ackPulse("ack0");
    idleCycles(2);
    applyStimulus("b11", 8'h11, 1'b1, ^8'h11, -1);
    applyStimulus("b22", 8'h22, 1'b1, ^8'h22, -1);
    checkOutput("overrun_set", 32'(overrun), 32'd1);
    ackPulse("ack1");

    // rd_ack landing exactly on the commit cycle of a second byte.
    idleCycles(2);
    applyStimulus("b33", 8'h33, 1'b1, ^8'h33, -1);
    applyStimulus("b44", 8'h44, 1'b1, ^8'h44, COMMIT - 1);
    checkOutput("ack_commit_ready", 32'(rx_ready), 32'd1);
    checkOutput("ack_commit_overrun", 32'(overrun), 32'd0);
    ackPulse("ack2");

`ifdef UART_RX_PARITY_EN
    // Wrong parity, then the same byte with correct parity.
    idleCycles(2);
    applyStimulus("par_bad", 8'h01, 1'b1, 1'b0, -1);
    applyStimulus("par_good", 8'h01, 1'b1, 1'b1, -1);
    ackPulse("ack3");
`endif

    // Random traffic, back to back, with occasional bad frames and acks.
    for (int i = 0; i < 8; i++) begin
      rnd     = 8'($urandom);
      stopRnd = ($urandom_range(0, 4) != 0);
      parRnd  = ($urandom_range(0, 4) != 0) ? ^rnd : ~(^rnd);
      ackRnd  = 1'($urandom_range(0, 1));
      applyStimulus($sformatf("rnd%0d", i), rnd, stopRnd, parRnd,
                    ackRnd ? COMMIT - 1 : -1);
      if (!stopRnd) idleCycles(6);
    end

    // Reset in the middle of a frame.
    idleCycles(2);
    rxd = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    checkOutput("mid_busy", 32'(busy), 32'd1);
    rxd = 1'b1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    expRdata = 8'h00; expReady = 1'b0; expOverrun = 1'b0;
    checkRegs("mid_reset");
    checkOutput("mid_reset_busy", 32'(busy), 32'd0);
    idleCycles(4);
    applyStimulus("after_rst", 8'h5A, 1'b1, ^8'h5A, -1);

    idleCycles(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Single-clock UART receiver for the board serial port: 8 data bits, LSB first, one stop bit, optional parity. Oversamples the asynchronous `rxd` pin and reassembles bytes. Drives the byte register that feeds the UART read-data RAM stage, with a `rx_ready`/`rd_ack` handshake toward the CPU-side UART status logic.

## Interface
- `CLK_DIV`, default 434: clock cycles per bit (50 MHz / 115200); must be even and ≥ 8.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous and active-low.
- `rxd`  in  1  asynchronous serial input; idle high.
- `rd_ack`  in  1  one-cycle pulse; consumer has taken `rdata`.
- `rdata`  out  8  last good byte; held until the next good byte.
- `rdata_valid`  out  1  one-cycle pulse when `rdata` is updated.
- `rx_ready`  out  1  sticky; an unread byte is present.
- `overrun`  out  1  sticky; a byte arrived while `rx_ready` = 1 without `rd_ack`.
- `frame_err`  out  1  one-cycle pulse; stop bit sampled low.
- `parity_err`  out  1  one-cycle pulse; exists only with `UART_RX_PARITY_EN`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- `rxd` passes through a 2-flop synchronizer. Both flops reset to 1. `rxs` is the synchronized value.
- States:
  - IDLE: `rxs` = 0 → START, bit counter cleared, divider cleared.
  - START: at divider = `CLK_DIV/2 - 1`, sample. 0 → DATA, divider cleared. 1 → IDLE (glitch, no flag).
  - DATA: at divider = `CLK_DIV - 1`, shift `rxs` into bit[n], n = 0..7. After bit 7 → STOP (or PARITY).
  - PARITY (macro only): sample one bit, then → STOP.
  - STOP: sample one bit. 1 → commit and → IDLE. 0 → `frame_err` and → BREAK.
  - BREAK: wait for `rxs` = 1, then → IDLE.
- Commit: `rdata` ← shift register; pulse `rdata_valid`; set `rx_ready`.
  - If `rx_ready` was 1 and there is no `rd_ack` in the same cycle, set `overrun`.
- A framing or parity error never updates `rdata` and never sets `rx_ready`.
- `rd_ack` clears both `rx_ready` and `overrun`.
  - If `rd_ack` and a commit fall in the same cycle: `rx_ready` stays 1 and `overrun` stays unchanged.
- Divider is log2(`CLK_DIV`) bits wide and wraps to 0 at each sample.

## Timing
- Reset values: `rdata` = 8'h00; `rdata_valid`, `rx_ready`, `overrun`, `frame_err`, `parity_err`, `busy` = 0; state = IDLE.
- T0 is the first cycle with `rxs` = 0, i.e. 2 cycles after the pin falls.
- Start sample at T0 + `CLK_DIV/2`. Data bit k is sampled at T0 + `CLK_DIV/2` + (k+1)·`CLK_DIV`. Stop is sampled at T0 + `CLK_DIV/2` + 9·`CLK_DIV`, or 10·`CLK_DIV` with parity.
- `rdata_valid`, `rdata`, `rx_ready` and `frame_err` change on the cycle after the stop sample. `busy` falls on that same cycle.
- A back-to-back start bit is accepted from the first IDLE cycle.
- `rst` low mid-frame: the frame is abandoned and all outputs take reset values on the next edge.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state, even parity, and the `parity_err` port are compiled in.
  - A mismatch pulses `parity_err` the cycle after the stop sample, with no commit.
  - If the stop bit is also low, `frame_err` is asserted as well.
- Undefined: no PARITY state and no `parity_err` port; the frame is 10 bits.

## Structure
- Shared package/header `uart_defs`: state encodings, `UART_DATA_BITS` = 8, default `CLK_DIV`. Shared with the transmitter.
- Sub-module `uart_rx_sync`: 2-flop synchronizer with reset value 1. Everything else is one FSM block plus a datapath.

## Test plan
Benches use `CLK_DIV` = 16.
- Send 8'hA5 with a good stop → `rdata_valid` pulse at T0 + 8 + 144 + 1, `rdata` = 8'hA5, `rx_ready` = 1, `frame_err` = 0.
- Low glitch of 4 cycles on `rxd` → `busy` rises then returns to IDLE at T0 + 8; no outputs change.
- Send 8'h3C with the stop bit low → `frame_err` pulse, `rdata` unchanged, `rx_ready` unchanged. Hold `rxd` low 40 cycles → stays in BREAK; release → IDLE.
- Send 8'h11 then 8'h22 with no `rd_ack` → `overrun` = 1, `rdata` = 8'h22. Then `rd_ack` → `rx_ready` = 0, `overrun` = 0.
- `rd_ack` on the exact commit cycle of a second byte → `rx_ready` = 1, `overrun` = 0.
- Parity build: send 8'h01 with parity bit 0 → `parity_err` pulse and no commit. Resend with parity bit 1 → commit of 8'h01.
